// File: rtl/elevator_request_scheduler.sv
// Call latching and SCAN-style goal selection for a three-floor car, plus the door dwell
// timer at each stop. The motion controller moves the car until floor matches goal_floor.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 3,
    parameter int FLOOR_W      = 2,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  button_reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  moving,
    input  logic                  sos_mode,
    input  logic                  weight_limit_exceeded,
    output logic [FLOOR_W-1:0]    goal_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  direction,
    output logic                  door_open,
    output logic                  arrived,
    output logic [2:0]            state_dbg
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_UP   = 3'd1,
        SERVE_DOWN = 3'd2,
        DWELL      = 3'd3,
        HALT       = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [FLOOR_W-1:0]    goal_n;
    logic                  dir_n;
    logic [CNT_W-1:0]      dwell_cnt, cnt_n;
    logic [NUM_FLOORS-1:0] pend_n;

    logic                  floor_valid, here;
    logic                  has_above, has_below, pick_up;
    logic [FLOOR_W-1:0]    up_tgt, dn_tgt, dist_up, dist_dn;
    logic                  go_dwell, go_up, go_down, go_idle;
    logic                  absorb;

    assign floor_valid = (int'(floor) < NUM_FLOORS);
    assign here        = floor_valid && pending[floor];

    // Nearest pending floor strictly above and strictly below the car.
    always_comb begin
        has_above = 1'b0;
        has_below = 1'b0;
        up_tgt    = '0;
        dn_tgt    = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(floor))) begin
                has_above = 1'b1;
                up_tgt    = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(floor))) begin
                has_below = 1'b1;
                dn_tgt    = FLOOR_W'(i);
            end
        end
    end

    assign dist_up = up_tgt - floor;
    assign dist_dn = floor - dn_tgt;
    // Equal distance resolves upward.
    assign pick_up = has_above && (!has_below || (dist_up <= dist_dn));

    always_comb begin
        state_n  = state;
        goal_n   = goal_floor;
        dir_n    = direction;
        cnt_n    = dwell_cnt;
        go_dwell = 1'b0;
        go_up    = 1'b0;
        go_down  = 1'b0;
        go_idle  = 1'b0;
        if (sos_mode) begin
            state_n = HALT;
            if (floor_valid) goal_n = floor;
        end else if (floor_valid) begin
            case (state)
                IDLE: begin
                    if (here && !moving) go_dwell = 1'b1;
                    else if (pick_up)    go_up    = 1'b1;
                    else if (has_below)  go_down  = 1'b1;
                end
                SERVE_UP: begin
                    if (floor == goal_floor) go_dwell = !moving;
                    else if (has_above)      go_up    = 1'b1;
                    else if (has_below)      go_down  = 1'b1;
                    else                     go_idle  = 1'b1;
                end
                SERVE_DOWN: begin
                    if (floor == goal_floor) go_dwell = !moving;
                    else if (has_below)      go_down  = 1'b1;
                    else if (has_above)      go_up    = 1'b1;
                    else                     go_idle  = 1'b1;
                end
                DWELL: begin
                    if (!weight_limit_exceeded) begin
                        if (dwell_cnt == CNT_LAST) begin
                            cnt_n   = '0;
                            go_up   = has_above && (direction || !has_below);
                            go_down = has_below && (!direction || !has_above);
                            go_idle = !has_above && !has_below;
                        end else begin
                            cnt_n = dwell_cnt + 1'b1;
                        end
                    end
                end
                HALT:    go_idle = 1'b1;
                default: go_idle = 1'b1;
            endcase

            if (go_dwell) begin
                state_n = DWELL;
                goal_n  = floor;
                cnt_n   = '0;
            end else if (go_up) begin
                state_n = SERVE_UP;
                dir_n   = 1'b1;
                goal_n  = up_tgt;
            end else if (go_down) begin
                state_n = SERVE_DOWN;
                dir_n   = 1'b0;
                goal_n  = dn_tgt;
            end else if (go_idle) begin
                state_n = IDLE;
            end
        end
    end

    // A call for the floor the door is open at is absorbed rather than re-latched.
    assign absorb = floor_valid && ((state == DWELL) || (state_n == DWELL));

    always_comb begin
        pend_n = pending;
        if (sos_mode) begin
            pend_n = '0;
        end else if (state != HALT) begin
            pend_n = pending | call_req;
            if (absorb) pend_n = pend_n & ~(NUM_FLOORS'(1) << floor);
        end
    end

    always_ff @(posedge clk) begin
        if (!button_reset_n) begin
            state      <= IDLE;
            pending    <= '0;
            goal_floor <= '0;
            direction  <= 1'b1;
            dwell_cnt  <= '0;
            arrived    <= 1'b0;
        end else begin
            state      <= state_n;
            pending    <= pend_n;
            goal_floor <= goal_n;
            direction  <= dir_n;
            dwell_cnt  <= cnt_n;
            arrived    <= (state_n == DWELL) && (state != DWELL);
        end
    end

    assign door_open = (state == DWELL);
    assign state_dbg = state;

endmodule
